// File: rtl/riscv_dift_exc_ctrl.sv
// DIFT exception controller: kills the offending EX instruction, flushes, holds a trap request until acked.
// kill_o is same-cycle; flush_o at N+1; trap_req_o from N+2 until ack. Optional log FIFO under DIFT_EXC_LOG_EN.
module riscv_dift_exc_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 ex_valid_i,
  input  logic                 exception_i,
  input  logic [2:0]           check_i,
  input  logic                 is_load_i,
  input  logic [31:0]          pc_ex_i,
  input  logic [31:0]          addr_ex_i,
  input  logic                 trap_ack_i,
  input  logic                 clr_i,
  output logic                 kill_o,
  output logic                 halt_o,
  output logic                 flush_o,
  output logic                 trap_req_o,
  output logic [3:0]           cause_o,
  output logic [31:0]          trap_pc_o,
  output logic [31:0]          trap_addr_o,
  output logic [CNT_WIDTH-1:0] exc_count_o,
  output logic                 overrun_o,
  input  logic                 log_rd_i,
  output logic                 log_empty_o,
  output logic [35:0]          log_data_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, TRAP = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cause_q, cause_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          addr_q, addr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovr_q, ovr_d;
  logic                 hit, accept, log_drop;

  assign hit    = ex_valid_i & exception_i & enable_i;
  assign accept = hit & (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FLUSH;
      FLUSH:   state_d = TRAP;
      TRAP:    if (trap_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cause_d = cause_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    if (accept) begin
      cause_d = {is_load_i, check_i};
      pc_d    = pc_ex_i;
      addr_d  = addr_ex_i;
    end
  end

  // Counter saturates; clear takes priority over a same-cycle violation.
  always_comb begin
    cnt_d = cnt_q;
    ovr_d = ovr_q;
    if (clr_i) begin
      cnt_d = '0;
      ovr_d = 1'b0;
    end else begin
      if (hit && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + CNT_WIDTH'(1);
      if ((hit && (state_q != IDLE)) || log_drop) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cause_q <= '0;
      pc_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign kill_o      = accept;
  assign flush_o     = (state_q == FLUSH);
  assign halt_o      = (state_q != IDLE);
  assign trap_req_o  = (state_q == TRAP);
  assign cause_o     = cause_q;
  assign trap_pc_o   = pc_q;
  assign trap_addr_o = addr_q;
  assign exc_count_o = cnt_q;
  assign overrun_o   = ovr_q;

`ifdef DIFT_EXC_LOG_EN
  localparam int PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

  logic [35:0]    log_mem_q [LOG_DEPTH];
  logic [35:0]    log_mem_d [LOG_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   lvl_q, lvl_d;
  logic           log_full, log_push, log_pop, push_ok;

  assign log_full = (lvl_q == (PTR_W+1)'(LOG_DEPTH));
  assign log_push = accept;
  assign log_pop  = log_rd_i & (lvl_q != '0);
  // A pop frees the slot in the same cycle, so push into a full FIFO still succeeds then.
  assign push_ok  = log_push & (~log_full | log_pop);
  assign log_drop = log_push & ~push_ok;

  always_comb begin
    log_mem_d = log_mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    lvl_d     = lvl_q;
    if (push_ok) begin
      log_mem_d[wr_ptr_q] = {is_load_i, check_i, pc_ex_i};
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (log_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !log_pop) lvl_d = lvl_q + (PTR_W+1)'(1);
    else if (!push_ok && log_pop) lvl_d = lvl_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LOG_DEPTH; i++) log_mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      lvl_q    <= '0;
    end else begin
      log_mem_q <= log_mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      lvl_q     <= lvl_d;
    end
  end

  assign log_empty_o = (lvl_q == '0);
  assign log_data_o  = log_mem_q[rd_ptr_q];
`else
  logic unused_log_rd;
  assign unused_log_rd = log_rd_i;
  assign log_drop      = 1'b0;
  assign log_empty_o   = 1'b1;
  assign log_data_o    = '0;
`endif

endmodule
